// File: rtl/sram_is61wv25616_ctrl_param_if.sv
// Host-side request/response bundle for the IS61WV25616 SRAM controller.
interface sram_is61wv25616_ctrl_param_if #(
  parameter int DW = 32,
  parameter int AW = 18
);
  logic            i_req;
  logic            i_we;
  logic [AW-1:0]   i_addr;
  logic [DW-1:0]   i_wdata;
  logic [DW/8-1:0] i_bmask;
  logic [DW-1:0]   o_rdata;
  logic            o_ack;
  logic            o_busy;

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_bmask,
    input  o_rdata, o_ack, o_busy
  );

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_bmask,
    output o_rdata, o_ack, o_busy
  );
endinterface

// File: rtl/sram_is61wv25616_ctrl_param.sv
// IS61WV25616 controller: one DW-bit host access as DW/16 half-word beats of 1+WAIT_CYC cycles.
// Optional macro SRAM_CTRL_RD_BYTE_MASK_EN zeroes unselected bytes of read data.
module sram_is61wv25616_ctrl_param #(
  parameter int DW       = 32,
  parameter int AW       = 18,
  parameter int WAIT_CYC = 0
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  sram_is61wv25616_ctrl_param_if.slave   bus,
  output logic [AW-1:0]                  SRAM_ADDR,
  inout  wire  [15:0]                    SRAM_DQ,
  output logic                           SRAM_CE_N,
  output logic                           SRAM_WE_N,
  output logic                           SRAM_OE_N,
  output logic                           SRAM_UB_N,
  output logic                           SRAM_LB_N
);
  localparam int              BEATS     = DW / 16;
  localparam int              BW        = $clog2(BEATS);
  localparam logic [BW-1:0]   LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]      WAIT_LAST = 4'(WAIT_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ACK} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [3:0]      wait_q, wait_d;
  logic            accept, beat_end;

  logic [AW-1:0]   base_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] bmask_q;
  logic            we_q;
  logic [DW-1:0]   rdata_q;

  logic            access;
  logic [1:0]      beat_mask;
  logic [15:0]     beat_wdata;
  logic [15:0]     rd_half;

  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    accept   = 1'b0;
    beat_end = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_ACK: begin
        if (bus.i_req) begin
          accept  = 1'b1;
          state_d = ST_ACCESS;
          beat_d  = '0;
          wait_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          beat_end = 1'b1;
          wait_d   = '0;
          if (beat_q == LAST_BEAT) state_d = ST_ACK;
          else                     beat_d  = beat_q + 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge (synchronous, active-low), and all
  // sequential state is updated with non-blocking assignments.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
    end
  end

  assign access     = (state_q == ST_ACCESS);
  assign beat_mask  = bmask_q[{beat_q, 1'b0} +: 2];
  assign beat_wdata = wdata_q[{beat_q, 4'b0000} +: 16];

`ifdef SRAM_CTRL_RD_BYTE_MASK_EN
  assign rd_half = {beat_mask[1] ? SRAM_DQ[15:8] : 8'h00,
                    beat_mask[0] ? SRAM_DQ[7:0]  : 8'h00};
`else
  assign rd_half = SRAM_DQ;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      base_q  <= '0;
      wdata_q <= '0;
      bmask_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        // Base is beat-aligned so base | beat walks the whole host word.
        base_q  <= bus.i_addr & ~AW'(BEATS - 1);
        wdata_q <= bus.i_wdata;
        bmask_q <= bus.i_bmask;
        we_q    <= bus.i_we;
      end
      if (beat_end && !we_q) rdata_q[{beat_q, 4'b0000} +: 16] <= rd_half;
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    SRAM_CE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_UB_N = 1'b1;
    SRAM_LB_N = 1'b1;
    if (access) begin
      SRAM_ADDR = base_q | {{(AW-BW){1'b0}}, beat_q};
      SRAM_CE_N = 1'b0;
      SRAM_WE_N = ~we_q;
      SRAM_OE_N = we_q;
      SRAM_UB_N = ~beat_mask[1];
      SRAM_LB_N = ~beat_mask[0];
    end
  end

  // The bus is only driven on write beats, when OE_N is guaranteed high.
  assign SRAM_DQ = (access && we_q) ? beat_wdata : 16'hzzzz;

  assign bus.o_rdata = rdata_q;
  assign bus.o_ack   = (state_q == ST_ACK);
  assign bus.o_busy  = access;
endmodule

// File: tb/tb_sram_is61wv25616_ctrl_param.sv
// Directed bench: a 32-bit/0-wait and a 64-bit/2-wait controller, each on a behavioural SRAM.
module tb_sram_is61wv25616_ctrl_param;
  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  sram_is61wv25616_ctrl_param_if #(.DW(32), .AW(18)) bus32 ();
  sram_is61wv25616_ctrl_param_if #(.DW(64), .AW(18)) bus64 ();

  logic [17:0] a32, a64;
  wire  [15:0] dq32, dq64;
  logic ce32, we32, oe32, ub32, lb32;
  logic ce64, we64, oe64, ub64, lb64;
  logic [15:0] mem32 [0:63];
  logic [15:0] mem64 [0:63];

  sram_is61wv25616_ctrl_param #(.DW(32), .AW(18), .WAIT_CYC(0)) dut32 (
    .i_clk(clk), .i_reset(rst_n), .bus(bus32.slave),
    .SRAM_ADDR(a32), .SRAM_DQ(dq32), .SRAM_CE_N(ce32), .SRAM_WE_N(we32),
    .SRAM_OE_N(oe32), .SRAM_UB_N(ub32), .SRAM_LB_N(lb32)
  );

  sram_is61wv25616_ctrl_param #(.DW(64), .AW(18), .WAIT_CYC(2)) dut64 (
    .i_clk(clk), .i_reset(rst_n), .bus(bus64.slave),
    .SRAM_ADDR(a64), .SRAM_DQ(dq64), .SRAM_CE_N(ce64), .SRAM_WE_N(we64),
    .SRAM_OE_N(oe64), .SRAM_UB_N(ub64), .SRAM_LB_N(lb64)
  );

  // Behavioural SRAMs: drive DQ on reads, latch enabled bytes on write cycles.
  assign dq32 = (!ce32 && !oe32 && we32) ? mem32[a32[5:0]] : 16'hzzzz;
  assign dq64 = (!ce64 && !oe64 && we64) ? mem64[a64[5:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce32 && !we32) begin
      if (!ub32) mem32[a32[5:0]][15:8] <= dq32[15:8];
      if (!lb32) mem32[a32[5:0]][7:0]  <= dq32[7:0];
    end
    if (!ce64 && !we64) begin
      if (!ub64) mem64[a64[5:0]][15:8] <= dq64[15:8];
      if (!lb64) mem64[a64[5:0]][7:0]  <= dq64[7:0];
    end
  end

  task automatic issue32(input logic we, input logic [17:0] addr, input logic [31:0] wd, input logic [3:0] bm);
    bus32.i_req = 1'b1; bus32.i_we = we; bus32.i_addr = addr; bus32.i_wdata = wd; bus32.i_bmask = bm;
    @(negedge clk);
    bus32.i_req = 1'b0;
  endtask

  task automatic issue64(input logic we, input logic [17:0] addr, input logic [63:0] wd, input logic [7:0] bm);
    bus64.i_req = 1'b1; bus64.i_we = we; bus64.i_addr = addr; bus64.i_wdata = wd; bus64.i_bmask = bm;
    @(negedge clk);
    bus64.i_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus32.i_req = 1'b0; bus32.i_we = 1'b0; bus32.i_addr = '0; bus32.i_wdata = '0; bus32.i_bmask = '0;
    bus64.i_req = 1'b0; bus64.i_we = 1'b0; bus64.i_addr = '0; bus64.i_wdata = '0; bus64.i_bmask = '0;
    repeat (3) @(negedge clk);
    tests_run++; if ({ce32, we32, oe32, ub32, lb32} !== 5'b11111) begin tests_failed++; $display("FAIL reset_strobes got=%b exp=11111", {ce32, we32, oe32, ub32, lb32}); end
    tests_run++; if ({bus32.o_ack, bus32.o_busy} !== 2'b00) begin tests_failed++; $display("FAIL reset_ack_busy got=%b exp=00", {bus32.o_ack, bus32.o_busy}); end
    tests_run++; if (bus32.o_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata got=%h exp=0", bus32.o_rdata); end
    tests_run++; if (a32 !== 18'h0) begin tests_failed++; $display("FAIL reset_addr got=%h exp=0", a32); end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++; if ({ce64, bus64.o_busy} !== 2'b10) begin tests_failed++; $display("FAIL reset_idle64 got=%b exp=10", {ce64, bus64.o_busy}); end
  endtask

  task automatic test_write();
    issue32(1'b1, 18'h00010, 32'hDEADBEEF, 4'hF);
    tests_run++; if (a32 !== 18'h10) begin tests_failed++; $display("FAIL wr_b0_addr got=%h exp=10", a32); end
    tests_run++; if (dq32 !== 16'hBEEF) begin tests_failed++; $display("FAIL wr_b0_dq got=%h exp=beef", dq32); end
    tests_run++; if ({ce32, we32, oe32, ub32, lb32} !== 5'b00100) begin tests_failed++; $display("FAIL wr_b0_strobes got=%b exp=00100", {ce32, we32, oe32, ub32, lb32}); end
    tests_run++; if ({bus32.o_busy, bus32.o_ack} !== 2'b10) begin tests_failed++; $display("FAIL wr_b0_busy got=%b exp=10", {bus32.o_busy, bus32.o_ack}); end
    @(negedge clk);
    tests_run++; if (a32 !== 18'h11) begin tests_failed++; $display("FAIL wr_b1_addr got=%h exp=11", a32); end
    tests_run++; if (dq32 !== 16'hDEAD) begin tests_failed++; $display("FAIL wr_b1_dq got=%h exp=dead", dq32); end
    tests_run++; if (bus32.o_ack !== 1'b0) begin tests_failed++; $display("FAIL wr_early_ack got=%b exp=0", bus32.o_ack); end
    @(negedge clk);
    tests_run++; if ({bus32.o_ack, bus32.o_busy} !== 2'b10) begin tests_failed++; $display("FAIL wr_ack got=%b exp=10", {bus32.o_ack, bus32.o_busy}); end
    tests_run++; if ({ce32, we32} !== 2'b11) begin tests_failed++; $display("FAIL wr_ack_strobes got=%b exp=11", {ce32, we32}); end
    tests_run++; if (dq32 === 16'hDEAD) begin tests_failed++; $display("FAIL wr_ack_dq_released got=%h exp=z", dq32); end
    @(negedge clk);
    tests_run++; if (bus32.o_ack !== 1'b0) begin tests_failed++; $display("FAIL wr_ack_pulse got=%b exp=0", bus32.o_ack); end
    tests_run++; if ({mem32[17], mem32[16]} !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL wr_mem got=%h exp=deadbeef", {mem32[17], mem32[16]}); end
  endtask

  task automatic test_read();
    issue32(1'b0, 18'h00011, 32'h0, 4'hF);
    tests_run++; if ({a32, oe32, we32} !== {18'h10, 2'b01}) begin tests_failed++; $display("FAIL rd_b0 got addr=%h oe=%b we=%b exp 10/0/1", a32, oe32, we32); end
    @(negedge clk);
    tests_run++; if ({a32, oe32, we32} !== {18'h11, 2'b01}) begin tests_failed++; $display("FAIL rd_b1 got addr=%h oe=%b we=%b exp 11/0/1", a32, oe32, we32); end
    @(negedge clk);
    tests_run++; if (bus32.o_ack !== 1'b1) begin tests_failed++; $display("FAIL rd_ack got=%b exp=1", bus32.o_ack); end
    tests_run++; if (bus32.o_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL rd_data got=%h exp=deadbeef", bus32.o_rdata); end
    @(negedge clk);
  endtask

  task automatic test_byte_mask();
    issue32(1'b1, 18'h00010, 32'h11223344, 4'b0010);
    tests_run++; if ({ce32, ub32, lb32} !== 3'b001) begin tests_failed++; $display("FAIL bm_b0 got=%b exp=001", {ce32, ub32, lb32}); end
    @(negedge clk);
    tests_run++; if ({ce32, ub32, lb32} !== 3'b011) begin tests_failed++; $display("FAIL bm_b1_masked got=%b exp=011", {ce32, ub32, lb32}); end
    @(negedge clk);
    tests_run++; if (bus32.o_ack !== 1'b1) begin tests_failed++; $display("FAIL bm_ack got=%b exp=1", bus32.o_ack); end
    tests_run++; if (bus32.o_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL bm_write_keeps_rdata got=%h exp=deadbeef", bus32.o_rdata); end
    @(negedge clk);
    issue32(1'b0, 18'h00010, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    tests_run++; if (bus32.o_rdata !== 32'hDEAD33EF) begin tests_failed++; $display("FAIL bm_readback got=%h exp=dead33ef", bus32.o_rdata); end
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    int  n;
    bit  got;
    int  extra_acks;
    logic [17:0] exp_addr;
    issue64(1'b1, 18'h00020, 64'h0123456789ABCDEF, 8'hFF);
    n = 1; got = 1'b0;
    while (n <= 40 && !got) begin
      if (bus64.o_ack) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    tests_run++; if (!got || n != 13) begin tests_failed++; $display("FAIL ws_write_latency got=%0d exp=13 (acked=%0d)", n, got); end
    @(negedge clk);
    issue64(1'b0, 18'h00023, 64'h0, 8'hFF);
    n = 1; got = 1'b0;
    while (n <= 40 && !got) begin
      if (bus64.o_ack) got = 1'b1;
      else begin
        exp_addr = 18'h20 + 18'((n - 1) / 3);
        tests_run++; if (a64 !== exp_addr || oe64 !== 1'b0) begin tests_failed++; $display("FAIL ws_beat_addr cyc=%0d got=%h oe=%b exp=%h oe=0", n, a64, oe64, exp_addr); end
        bus64.i_req = (n == 4);
        @(negedge clk); n++;
      end
    end
    bus64.i_req = 1'b0;
    tests_run++; if (!got || n != 13) begin tests_failed++; $display("FAIL ws_read_latency got=%0d exp=13 (acked=%0d)", n, got); end
    tests_run++; if (bus64.o_rdata !== 64'h0123456789ABCDEF) begin tests_failed++; $display("FAIL ws_rdata got=%h exp=0123456789abcdef", bus64.o_rdata); end
    extra_acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus64.o_ack || bus64.o_busy) extra_acks++;
    end
    tests_run++; if (extra_acks != 0) begin tests_failed++; $display("FAIL ws_ignored_req got=%0d extra cycles busy/ack exp=0", extra_acks); end
  endtask

  task automatic test_back_to_back();
    issue32(1'b1, 18'h00012, 32'hCAFEF00D, 4'hF);
    repeat (2) @(negedge clk);
    tests_run++; if (bus32.o_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_ack got=%b exp=1", bus32.o_ack); end
    issue32(1'b1, 18'h00014, 32'h5555AAAA, 4'hF);
    tests_run++; if ({bus32.o_busy, bus32.o_ack, a32} !== {2'b10, 18'h14}) begin tests_failed++; $display("FAIL b2b_no_bubble got busy=%b ack=%b addr=%h exp 1/0/14", bus32.o_busy, bus32.o_ack, a32); end
    @(negedge clk);
    tests_run++; if (bus32.o_ack !== 1'b0) begin tests_failed++; $display("FAIL b2b_mid got=%b exp=0", bus32.o_ack); end
    @(negedge clk);
    tests_run++; if (bus32.o_ack !== 1'b1) begin tests_failed++; $display("FAIL b2b_second_ack got=%b exp=1", bus32.o_ack); end
    tests_run++; if ({mem32[21], mem32[20], mem32[18]} !== 48'h5555AAAAF00D) begin tests_failed++; $display("FAIL b2b_mem got=%h exp=5555aaaaf00d", {mem32[21], mem32[20], mem32[18]}); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int acks;
    issue32(1'b1, 18'h00016, 32'h76543210, 4'hF);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if ({ce32, we32, oe32, ub32, lb32} !== 5'b11111) begin tests_failed++; $display("FAIL abort_strobes got=%b exp=11111", {ce32, we32, oe32, ub32, lb32}); end
    tests_run++; if (dq32 === 16'h7654) begin tests_failed++; $display("FAIL abort_dq_released got=%h exp=z", dq32); end
    tests_run++; if ({a32, bus32.o_busy, bus32.o_ack} !== 20'h0) begin tests_failed++; $display("FAIL abort_state got addr=%h busy=%b ack=%b exp 0", a32, bus32.o_busy, bus32.o_ack); end
    tests_run++; if (bus32.o_rdata !== 32'h0) begin tests_failed++; $display("FAIL abort_rdata got=%h exp=0", bus32.o_rdata); end
    rst_n = 1'b1;
    acks = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus32.o_ack) acks++;
    end
    tests_run++; if (acks != 0) begin tests_failed++; $display("FAIL abort_no_ack got=%0d exp=0", acks); end
    issue32(1'b0, 18'h00010, 32'h0, 4'b0001);
    repeat (2) @(negedge clk);
    tests_run++; if (bus32.o_ack !== 1'b1) begin tests_failed++; $display("FAIL mask_rd_ack got=%b exp=1", bus32.o_ack); end
`ifdef SRAM_CTRL_RD_BYTE_MASK_EN
    tests_run++; if (bus32.o_rdata !== 32'h000000EF) begin tests_failed++; $display("FAIL mask_rd_data got=%h exp=000000ef", bus32.o_rdata); end
`else
    tests_run++; if (bus32.o_rdata !== 32'hDEAD33EF) begin tests_failed++; $display("FAIL mask_rd_data got=%h exp=dead33ef", bus32.o_rdata); end
`endif
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_byte_mask();
    test_wait_states();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
